// File: rtl/blend_pipe_if.sv
// blend_pipe_if: upstream beat, blend controls and downstream result handshake for blend_pipe.
// Revision 1.0
`default_nettype none

interface blend_pipe_if #(
  parameter int BG_W = 5,
  parameter int PX_W = 8
);
  logic            i_valid;
  logic            o_ready;
  logic [BG_W-1:0] i_bg_r;
  logic [BG_W-1:0] i_bg_g;
  logic [BG_W-1:0] i_bg_b;
  logic            i_bg_mask;
  logic [PX_W-1:0] i_px_r;
  logic [PX_W-1:0] i_px_g;
  logic [PX_W-1:0] i_px_b;
  logic            i_px_stp;
  logic            i_px_transparent;
  logic            i_semi_en;
  logic [1:0]      i_mode;
  logic            i_check_mask;
  logic            i_force_mask;
  logic            o_valid;
  logic            i_ready;
  logic [PX_W-1:0] o_r;
  logic [PX_W-1:0] o_g;
  logic [PX_W-1:0] o_b;
  logic            o_mask;
  logic            o_write;

  modport master (
    output i_valid, i_bg_r, i_bg_g, i_bg_b, i_bg_mask,
    output i_px_r, i_px_g, i_px_b, i_px_stp, i_px_transparent,
    output i_semi_en, i_mode, i_check_mask, i_force_mask, i_ready,
    input  o_ready, o_valid, o_r, o_g, o_b, o_mask, o_write
  );

  modport slave (
    input  i_valid, i_bg_r, i_bg_g, i_bg_b, i_bg_mask,
    input  i_px_r, i_px_g, i_px_b, i_px_stp, i_px_transparent,
    input  i_semi_en, i_mode, i_check_mask, i_force_mask, i_ready,
    output o_ready, o_valid, o_r, o_g, o_b, o_mask, o_write
  );
endinterface

`default_nettype wire

// File: rtl/blend_pipe.sv
// blend_pipe: two-stage semi-transparency blender (expand/raw sum, then clamp/select).
// Revision 1.0
`default_nettype none

module blend_pipe #(
  parameter int BG_W = 5,
  parameter int PX_W = 8
) (
  input  logic       clk,
  input  logic       i_nrst,
  blend_pipe_if.slave bus
);
  localparam int SW = PX_W + 2;

  logic            en;
  logic [BG_W-1:0] bg_in  [3];
  logic [PX_W-1:0] px_in  [3];
  logic [PX_W-1:0] bg_exp [3];

  logic            s1_valid;
  logic [SW-1:0]   s1_raw [3];
  logic [PX_W-1:0] s1_px  [3];
  logic            s1_blend;
  logic            s1_write;
  logic            s1_mask;

  logic            s2_valid;
  logic [PX_W-1:0] s2_px  [3];
  logic            s2_write;
  logic            s2_mask;

  function automatic logic [SW-1:0] blend_raw(input logic [PX_W-1:0] bge,
                                              input logic [PX_W-1:0] px,
                                              input logic [1:0]      mode);
    logic [SW-1:0] a;
    logic [SW-1:0] b;
    a = SW'(bge);
    b = SW'(px);
    case (mode)
      2'd0:    blend_raw = (a + b) >> 1;
      2'd1:    blend_raw = a + b;
      2'd2:    blend_raw = a - b;
      default: blend_raw = a + (b >> 2);
    endcase
  endfunction

  // Top bit is the sign of a wrapped subtraction; the next bit flags overflow past MAX.
  function automatic logic [PX_W-1:0] clamp(input logic [SW-1:0] v);
    if (v[SW-1])
      clamp = '0;
    else if (v[SW-2])
      clamp = '1;
    else
      clamp = v[PX_W-1:0];
  endfunction

  assign bg_in[0] = bus.i_bg_r;
  assign bg_in[1] = bus.i_bg_g;
  assign bg_in[2] = bus.i_bg_b;
  assign px_in[0] = bus.i_px_r;
  assign px_in[1] = bus.i_px_g;
  assign px_in[2] = bus.i_px_b;

  generate
    for (genvar c = 0; c < 3; c++) begin : g_chan
      if (PX_W > BG_W) begin : g_expand
        assign bg_exp[c] = {bg_in[c], bg_in[c][BG_W-1 -: PX_W-BG_W]};
      end else begin : g_same
        assign bg_exp[c] = bg_in[c];
      end
    end
  endgenerate

  assign en          = !s2_valid | bus.i_ready;
  assign bus.o_ready = en;

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      s1_valid <= 1'b0;
      s1_blend <= 1'b0;
      s1_write <= 1'b0;
      s1_mask  <= 1'b0;
      s2_valid <= 1'b0;
      s2_write <= 1'b0;
      s2_mask  <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        s1_raw[c] <= '0;
        s1_px[c]  <= '0;
        s2_px[c]  <= '0;
      end
    end else if (en) begin
      s1_valid <= bus.i_valid;
      s1_blend <= bus.i_semi_en & bus.i_px_stp;
      s1_write <= !(bus.i_px_transparent | (bus.i_check_mask & bus.i_bg_mask));
      s1_mask  <= bus.i_force_mask | bus.i_px_stp;
      s2_valid <= s1_valid;
      s2_write <= s1_write;
      s2_mask  <= s1_mask;
      for (int c = 0; c < 3; c++) begin
        s1_raw[c] <= blend_raw(bg_exp[c], px_in[c], bus.i_mode);
        s1_px[c]  <= px_in[c];
        s2_px[c]  <= s1_blend ? clamp(s1_raw[c]) : s1_px[c];
      end
    end
  end

  assign bus.o_valid = s2_valid;
  assign bus.o_r     = s2_px[0];
  assign bus.o_g     = s2_px[1];
  assign bus.o_b     = s2_px[2];
  assign bus.o_write = s2_write;
  assign bus.o_mask  = s2_mask;

endmodule

`default_nettype wire

// File: tb/tb_blend_pipe.sv
// tb_blend_pipe: directed and random self-checking bench for blend_pipe (BG_W=5, PX_W=8).
// Revision 1.0
`default_nettype none

module tb_blend_pipe;
  logic clk = 1'b0;
  logic nrst;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    logic [7:0] r, g, b;
    logic       w, m;
  } exp_t;

  blend_pipe_if #(.BG_W(5), .PX_W(8)) bus ();
  blend_pipe #(.BG_W(5), .PX_W(8)) dut (.clk(clk), .i_nrst(nrst), .bus(bus));

  always #5 clk = ~clk;

  task automatic set_beat(input int bgr, bgg, bgb, pxr, pxg, pxb,
                          input bit stp, semi, transp, bgmask, chk, frc, input int mode);
    bus.i_bg_r = 5'(bgr); bus.i_bg_g = 5'(bgg); bus.i_bg_b = 5'(bgb);
    bus.i_px_r = 8'(pxr); bus.i_px_g = 8'(pxg); bus.i_px_b = 8'(pxb);
    bus.i_px_stp = stp; bus.i_semi_en = semi; bus.i_px_transparent = transp;
    bus.i_bg_mask = bgmask; bus.i_check_mask = chk; bus.i_force_mask = frc;
    bus.i_mode = 2'(mode);
  endtask

  // Sends the staged beat, samples it two edges later, then lets it drain.
  task automatic run_beat(output logic [7:0] r, g, b, output logic w, m, output bit timely);
    bus.i_valid = 1'b1; bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    timely = (bus.o_valid === 1'b0);
    @(posedge clk); #1;
    timely = timely && (bus.o_valid === 1'b1);
    r = bus.o_r; g = bus.o_g; b = bus.o_b; w = bus.o_write; m = bus.o_mask;
    @(posedge clk); #1;
  endtask

  function automatic int exp_chan(int bg, int px, int mode, bit blend);
    int e, v;
    e = bg * 8 + bg / 4;
    if (!blend) return px;
    case (mode)
      0: v = (e + px) / 2;
      1: v = e + px;
      2: v = e - px;
      default: v = e + px / 4;
    endcase
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  task automatic test_reset();
    tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b exp=0", bus.o_valid); end
    tests++; if ({bus.o_r, bus.o_g, bus.o_b} !== 24'h0) begin fails++; $display("FAIL rst_data got=%h exp=0", {bus.o_r, bus.o_g, bus.o_b}); end
    tests++; if ({bus.o_write, bus.o_mask} !== 2'b00) begin fails++; $display("FAIL rst_wm got=%b exp=00", {bus.o_write, bus.o_mask}); end
    tests++; if (bus.o_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got=%b exp=1", bus.o_ready); end
  endtask

  task automatic test_modes01();
    logic [7:0] r, g, b; logic w, m; bit t;
    set_beat(31, 0, 31, 64, 64, 255, 1, 1, 0, 0, 0, 0, 0);
    run_beat(r, g, b, w, m, t);
    tests++; if (!t) begin fails++; $display("FAIL m0_latency got=late exp=2cycles"); end
    tests++; if (r !== 8'd159) begin fails++; $display("FAIL m0_r got=%0d exp=159", r); end
    tests++; if (g !== 8'd32)  begin fails++; $display("FAIL m0_g got=%0d exp=32", g); end
    tests++; if (b !== 8'd255) begin fails++; $display("FAIL m0_b got=%0d exp=255", b); end
    tests++; if ({w, m} !== 2'b11) begin fails++; $display("FAIL m0_wm got=%b exp=11", {w, m}); end
    set_beat(16, 0, 1, 200, 10, 5, 1, 1, 0, 0, 0, 0, 1);
    run_beat(r, g, b, w, m, t);
    tests++; if (r !== 8'd255) begin fails++; $display("FAIL m1_r got=%0d exp=255", r); end
    tests++; if (g !== 8'd10)  begin fails++; $display("FAIL m1_g got=%0d exp=10", g); end
    tests++; if (b !== 8'd13)  begin fails++; $display("FAIL m1_b got=%0d exp=13", b); end
  endtask

  task automatic test_modes23();
    logic [7:0] r, g, b; logic w, m; bit t;
    set_beat(8, 31, 16, 100, 55, 132, 1, 1, 0, 0, 0, 0, 2);
    run_beat(r, g, b, w, m, t);
    tests++; if (r !== 8'd0)   begin fails++; $display("FAIL m2_r got=%0d exp=0", r); end
    tests++; if (g !== 8'd200) begin fails++; $display("FAIL m2_g got=%0d exp=200", g); end
    tests++; if (b !== 8'd0)   begin fails++; $display("FAIL m2_b got=%0d exp=0", b); end
    set_beat(4, 31, 2, 255, 4, 3, 1, 1, 0, 0, 0, 0, 3);
    run_beat(r, g, b, w, m, t);
    tests++; if (r !== 8'd96)  begin fails++; $display("FAIL m3_r got=%0d exp=96", r); end
    tests++; if (g !== 8'd255) begin fails++; $display("FAIL m3_g got=%0d exp=255", g); end
    tests++; if (b !== 8'd16)  begin fails++; $display("FAIL m3_b got=%0d exp=16", b); end
  endtask

  task automatic test_passthru_discard();
    logic [7:0] r, g, b; logic w, m; bit t;
    set_beat(31, 31, 31, 7, 100, 0, 0, 1, 0, 0, 0, 0, 1);
    run_beat(r, g, b, w, m, t);
    tests++; if ({r, g, b} !== {8'd7, 8'd100, 8'd0}) begin fails++; $display("FAIL pass_stp0 got=%0d,%0d,%0d exp=7,100,0", r, g, b); end
    tests++; if ({w, m} !== 2'b10) begin fails++; $display("FAIL pass_stp0_wm got=%b exp=10", {w, m}); end
    set_beat(31, 31, 31, 64, 64, 64, 1, 0, 0, 0, 0, 0, 0);
    run_beat(r, g, b, w, m, t);
    tests++; if (r !== 8'd64 || m !== 1'b1) begin fails++; $display("FAIL pass_semi0 got=%0d/%b exp=64/1", r, m); end
    set_beat(1, 1, 1, 9, 9, 9, 0, 0, 1, 0, 0, 0, 0);
    run_beat(r, g, b, w, m, t);
    tests++; if (w !== 1'b0) begin fails++; $display("FAIL transparent_w got=%b exp=0", w); end
    set_beat(1, 1, 1, 9, 9, 9, 0, 0, 0, 1, 1, 0, 0);
    run_beat(r, g, b, w, m, t);
    tests++; if (w !== 1'b0) begin fails++; $display("FAIL maskchk_w got=%b exp=0", w); end
    set_beat(1, 1, 1, 9, 9, 9, 0, 0, 0, 1, 0, 0, 0);
    run_beat(r, g, b, w, m, t);
    tests++; if (w !== 1'b1) begin fails++; $display("FAIL nochk_w got=%b exp=1", w); end
    set_beat(1, 1, 1, 9, 9, 9, 0, 0, 0, 0, 1, 0, 0);
    run_beat(r, g, b, w, m, t);
    tests++; if (w !== 1'b1) begin fails++; $display("FAIL chk_nomask_w got=%b exp=1", w); end
    set_beat(1, 1, 1, 9, 9, 9, 0, 0, 0, 0, 0, 1, 0);
    run_beat(r, g, b, w, m, t);
    tests++; if (m !== 1'b1) begin fails++; $display("FAIL force_m got=%b exp=1", m); end
  endtask

  task automatic test_back_to_back_stall();
    logic [7:0] pxs [3];
    int sent = 0;
    int got  = 0;
    pxs[0] = 8'd11; pxs[1] = 8'd22; pxs[2] = 8'd33;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      if (sent < 3) begin
        set_beat(3, 3, 3, pxs[sent], pxs[sent], pxs[sent], 0, 0, 0, 0, 0, 0, 1);
        bus.i_valid = 1'b1;
      end else begin
        bus.i_valid = 1'b0;
      end
      bus.i_ready = !(cyc >= 2 && cyc <= 4);
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        tests++; if (bus.o_ready !== 1'b0) begin fails++; $display("FAIL stall_ready c%0d got=%b exp=0", cyc, bus.o_ready); end
        tests++; if (bus.o_valid !== 1'b1 || bus.o_r !== pxs[0]) begin fails++; $display("FAIL stall_hold c%0d got=%b/%0d exp=1/%0d", cyc, bus.o_valid, bus.o_r, pxs[0]); end
      end
      if (bus.o_valid && bus.i_ready) begin
        tests++; if (bus.o_r !== pxs[got]) begin fails++; $display("FAIL stall_order beat%0d got=%0d exp=%0d", got, bus.o_r, pxs[got]); end
        got++;
      end
      if (bus.i_valid && bus.o_ready) sent++;
      @(posedge clk); #1;
    end
    bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    tests++; if (got != 3) begin fails++; $display("FAIL stall_count got=%0d exp=3", got); end
    #1;
    tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL stall_dup got=%b exp=0", bus.o_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    logic [7:0] r, g, b; logic w, m; bit t;
    set_beat(5, 5, 5, 50, 50, 50, 0, 0, 0, 0, 0, 1, 0);
    bus.i_valid = 1'b1; bus.i_ready = 1'b1;
    @(posedge clk); #1;
    set_beat(5, 5, 5, 60, 60, 60, 0, 0, 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    tests++; if (bus.o_valid !== 1'b1) begin fails++; $display("FAIL pre_rst_valid got=%b exp=1", bus.o_valid); end
    nrst = 1'b0;
    #1;
    tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL async_rst_valid got=%b exp=0", bus.o_valid); end
    tests++; if ({bus.o_r, bus.o_write, bus.o_mask} !== 10'h0) begin fails++; $display("FAIL async_rst_data got=%h exp=0", {bus.o_r, bus.o_write, bus.o_mask}); end
    @(posedge clk); #1;
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL stale_beat c%0d got=%b exp=0", i, bus.o_valid); end
    end
    set_beat(0, 0, 0, 77, 77, 77, 0, 0, 0, 0, 0, 0, 0);
    run_beat(r, g, b, w, m, t);
    tests++; if (!t || r !== 8'd77) begin fails++; $display("FAIL post_rst_beat got=%0d timely=%0d exp=77 timely=1", r, t); end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e, h;
    int acc = 0;
    int cyc = 0;
    int bg[3], px[3], mode;
    bit stp, semi, tr, bm, chk, frc;
    while (acc < 10000 && cyc < 40000) begin
      for (int c = 0; c < 3; c++) begin bg[c] = $urandom_range(0, 31); px[c] = $urandom_range(0, 255); end
      mode = $urandom_range(0, 3);
      stp = 1'($urandom); semi = 1'($urandom); tr = ($urandom_range(0, 7) == 0);
      bm = 1'($urandom); chk = 1'($urandom); frc = 1'($urandom);
      set_beat(bg[0], bg[1], bg[2], px[0], px[1], px[2], stp, semi, tr, bm, chk, frc, mode);
      bus.i_valid = ($urandom_range(0, 3) != 0);
      bus.i_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (bus.o_valid && bus.i_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL rnd_extra cyc%0d got=beat exp=none", cyc);
        end else begin
          h = q.pop_front();
          if ({bus.o_r, bus.o_g, bus.o_b, bus.o_write, bus.o_mask} !== {h.r, h.g, h.b, h.w, h.m}) begin
            fails++;
            $display("FAIL rnd_beat cyc%0d got=%h,%h,%h,%b,%b exp=%h,%h,%h,%b,%b", cyc,
                     bus.o_r, bus.o_g, bus.o_b, bus.o_write, bus.o_mask, h.r, h.g, h.b, h.w, h.m);
          end
        end
      end
      if (bus.i_valid && bus.o_ready) begin
        e.r = 8'(exp_chan(bg[0], px[0], mode, semi && stp));
        e.g = 8'(exp_chan(bg[1], px[1], mode, semi && stp));
        e.b = 8'(exp_chan(bg[2], px[2], mode, semi && stp));
        e.w = !(tr || (chk && bm));
        e.m = frc || stp;
        q.push_back(e);
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      #1;
      if (bus.o_valid) begin
        h = q.pop_front();
        tests++;
        if ({bus.o_r, bus.o_g, bus.o_b, bus.o_write, bus.o_mask} !== {h.r, h.g, h.b, h.w, h.m}) begin
          fails++; $display("FAIL rnd_drain_beat got=%h,%h,%h exp=%h,%h,%h", bus.o_r, bus.o_g, bus.o_b, h.r, h.g, h.b);
        end
      end
      @(posedge clk); #1;
    end
    tests++; if (q.size() != 0 || acc < 10000) begin fails++; $display("FAIL rnd_complete got=acc%0d left%0d exp=acc10000 left0", acc, q.size()); end
  endtask

  initial begin
    nrst = 1'b0;
    set_beat(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    nrst = 1'b1;
    @(posedge clk); #1;
    test_modes01();
    test_modes23();
    test_passthru_discard();
    test_back_to_back_stall();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
